// File: rtl/nfm_pkg.sv
// Shared types and default widths for the exp-sum accumulator slice.
// FSM state encoding, element counter width and fixed-point defaults.
package nfm_pkg;

   localparam int BF_D      = 8;
   localparam int FPW_D     = 16;
   localparam int ACC_W_D   = 24;
   localparam int LEN_W     = 8;
   localparam int CNT_W     = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } acc_state_e;

endpackage

// File: rtl/exp_sum_acc_if.sv
// Control, input stream and result handshake of the accumulator.
// master = producer/consumer side, slave = accumulator side.
interface exp_sum_acc_if
   import nfm_pkg::*;
#(
   parameter int FPW = FPW_D,
   parameter int AW  = ACC_W_D
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [FPW-1:0]   in_data;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out_sum;
   logic             out_sat;
   logic             busy;

   modport master (
      output start, len, clr, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_sat, busy
   );

   modport slave (
      input  start, len, clr, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_sat, busy
   );
endinterface

// File: rtl/sat_add.sv
// Unsigned saturating adder: narrow addend zero-extended onto wide one.
// Sum clamps to all-ones and flags overflow when the carry-out is set.
module sat_add #(
   parameter int AW = 24,
   parameter int BW = 16
) (
   input  logic [AW-1:0] i_a,
   input  logic [BW-1:0] i_b,
   output logic [AW-1:0] o_sum,
   output logic          o_ovf
);
   logic [AW:0] w_full;

   // full-width add with one guard bit, then clamp on carry
   always_comb begin
      w_full = {1'b0, i_a} + {{(AW + 1 - BW){1'b0}}, i_b};
      o_ovf  = w_full[AW];
      o_sum  = o_ovf ? {AW{1'b1}} : w_full[AW-1:0];
   end
endmodule

// File: rtl/exp_sum_acc.sv
// Accumulates a vector of exp2 results into a saturating unsigned sum.
// IDLE -> ACCUM (len beats, 0 = 256) -> DONE until the result is taken.
module exp_sum_acc
   import nfm_pkg::*;
#(
   parameter int Bf              = BF_D,
   parameter int FIX_POINT_WIDTH = FPW_D,
   parameter int ACC_WIDTH       = ACC_W_D
) (
   input  logic         clk,
   input  logic         rst_n,
   exp_sum_acc_if.slave bus
);
   generate
      if (ACC_WIDTH < FIX_POINT_WIDTH + 1 || Bf > FIX_POINT_WIDTH)
      begin : g_bad_param
         $error("exp_sum_acc: illegal width parameters");
      end
   endgenerate

   acc_state_e           r_state;
   acc_state_e           w_next;
   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] w_sum;
   logic                 w_ovf;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_target;
   logic [LEN_W-1:0]     r_len;
   logic                 r_sat;
   logic                 w_beat;
   logic                 w_last;

   sat_add #(
      .AW (ACC_WIDTH),
      .BW (FIX_POINT_WIDTH)
   ) u_sat_add (
      .i_a   (r_acc),
      .i_b   (bus.in_data),
      .o_sum (w_sum),
      .o_ovf (w_ovf)
   );

   // element count decode and beat/last-beat qualifiers
   always_comb begin
      w_target = (r_len == '0) ? CNT_W'(256) : {1'b0, r_len};
      w_beat   = (r_state == ST_ACCUM) && bus.in_valid;
      w_last   = w_beat && ((r_cnt + CNT_W'(1)) == w_target);
   end

   // next-state logic; clr overrides everything
   always_comb begin
      w_next = r_state;
      if (bus.clr) begin
         w_next = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE:  if (bus.start)     w_next = ST_ACCUM;
            ST_ACCUM: if (w_last)        w_next = ST_DONE;
            ST_DONE:  if (bus.out_ready) w_next = ST_IDLE;
            default:                     w_next = ST_IDLE;
         endcase
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // datapath: latch len on start, accumulate accepted beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_len <= '0;
         r_sat <= 1'b0;
      end else if (bus.clr) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_len <= '0;
         r_sat <= 1'b0;
      end else if (r_state == ST_IDLE && bus.start) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_len <= bus.len;
         r_sat <= 1'b0;
      end else if (w_beat) begin
         r_acc <= w_sum;
         r_cnt <= r_cnt + CNT_W'(1);
         r_sat <= r_sat | w_ovf;
      end
   end

   // outputs decoded from state; result gated to zero outside DONE
   always_comb begin
      bus.in_ready  = (r_state == ST_ACCUM);
      bus.out_valid = (r_state == ST_DONE);
      bus.busy      = (r_state != ST_IDLE);
      bus.out_sum   = (r_state == ST_DONE) ? r_acc : '0;
      bus.out_sat   = (r_state == ST_DONE) ? r_sat : 1'b0;
   end
endmodule

// File: tb/tb_exp_sum_acc.sv
// Directed bench for exp_sum_acc: default widths plus a 17-bit
// accumulator instance for the saturation case.
module tb_exp_sum_acc;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   n_acc;

   exp_sum_acc_if #(.FPW(16), .AW(24)) bus ();
   exp_sum_acc_if #(.FPW(16), .AW(17)) bus17 ();

   exp_sum_acc #(
      .Bf (8), .FIX_POINT_WIDTH (16), .ACC_WIDTH (24)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_sum_acc #(
      .Bf (8), .FIX_POINT_WIDTH (16), .ACC_WIDTH (17)
   ) u_dut17 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus17)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  32'h0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
      chk({tag, "_out_sum"},   32'(bus.out_sum),   32'h0);
      chk({tag, "_out_sat"},   32'(bus.out_sat),   32'h0);
      chk({tag, "_busy"},      32'(bus.busy),      32'h0);
   endtask

   task automatic take_result();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] beats [4];
      n_checks = 0;
      n_errors = 0;
      beats[0] = 16'h0100;
      beats[1] = 16'h0080;
      beats[2] = 16'h0040;
      beats[3] = 16'h0020;

      rst_n = 1'b0;
      bus.start = 0; bus.len = 0; bus.clr = 0;
      bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
      bus17.start = 0; bus17.len = 0; bus17.clr = 0;
      bus17.in_valid = 0; bus17.in_data = 0; bus17.out_ready = 0;
      #12;
      chk_idle("reset");
      rst_n = 1'b1;
      tick();

      // four beats with a stall cycle in the middle
      bus.start = 1; bus.len = 8'd4;
      tick();
      bus.start = 0;
      chk("t1_in_ready", 32'(bus.in_ready), 32'h1);
      chk("t1_busy", 32'(bus.busy), 32'h1);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            bus.in_valid = 0;
            tick();
         end
         bus.in_valid = 1; bus.in_data = beats[i];
         if (i == 3) begin
            chk("t1_pre_valid", 32'(bus.out_valid), 32'h0);
            chk("t1_pre_sum", 32'(bus.out_sum), 32'h0);
         end
         tick();
      end
      bus.in_valid = 0;
      chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
      chk("t1_out_sum", 32'(bus.out_sum), 32'h0001E0);
      chk("t1_out_sat", 32'(bus.out_sat), 32'h0);
      chk("t1_done_in_ready", 32'(bus.in_ready), 32'h0);

      // hold in DONE with start pulses and stray input beats
      for (int i = 0; i < 5; i++) begin
         bus.start = (i % 2 == 0); bus.len = 8'd1;
         bus.in_valid = 1; bus.in_data = 16'h0FFF;
         tick();
         chk("hold_valid", 32'(bus.out_valid), 32'h1);
         chk("hold_sum", 32'(bus.out_sum), 32'h0001E0);
      end
      bus.in_valid = 0;
      bus.start = 1;
      take_result();
      bus.start = 0;
      chk_idle("after_take");
      tick();
      chk("start_on_take_ignored", 32'(bus.busy), 32'h0);

      // len = 0 means 256 beats
      bus.start = 1; bus.len = 8'd0;
      tick();
      bus.start = 0;
      bus.in_valid = 1; bus.in_data = 16'h0100;
      n_acc = 0;
      for (int i = 0; i < 256; i++) begin
         if (bus.in_ready) n_acc++;
         tick();
      end
      bus.in_valid = 0;
      chk("t2_beats", 32'(n_acc), 32'd256);
      chk("t2_in_ready_257", 32'(bus.in_ready), 32'h0);
      chk("t2_out_valid", 32'(bus.out_valid), 32'h1);
      chk("t2_out_sum", 32'(bus.out_sum), 32'h010000);
      chk("t2_out_sat", 32'(bus.out_sat), 32'h0);
      take_result();

      // clr after two of four beats
      bus.start = 1; bus.len = 8'd4;
      tick();
      bus.start = 0;
      bus.in_valid = 1; bus.in_data = 16'h0100;
      tick();
      tick();
      bus.in_valid = 0; bus.clr = 1; bus.out_ready = 1;
      tick();
      bus.clr = 0; bus.out_ready = 0;
      chk_idle("clr");
      tick();
      chk("clr_no_valid", 32'(bus.out_valid), 32'h0);
      bus.start = 1; bus.len = 8'd1;
      tick();
      bus.start = 0;
      bus.in_valid = 1; bus.in_data = 16'h0005;
      tick();
      bus.in_valid = 0;
      chk("t3_out_valid", 32'(bus.out_valid), 32'h1);
      chk("t3_out_sum", 32'(bus.out_sum), 32'h000005);
      take_result();

      // asynchronous reset in the middle of a vector
      bus.start = 1; bus.len = 8'd4;
      tick();
      bus.start = 0;
      bus.in_valid = 1; bus.in_data = 16'h0100;
      tick();
      rst_n = 1'b0;
      #1;
      chk_idle("mid_rst");
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_stay_idle", 32'(bus.busy), 32'h0);
      end
      bus.start = 1; bus.len = 8'd1; bus.in_data = 16'h0007;
      bus.in_valid = 0;
      tick();
      bus.start = 0; bus.in_valid = 1;
      tick();
      bus.in_valid = 0;
      chk("t4_out_sum", 32'(bus.out_sum), 32'h000007);
      take_result();

      // 17-bit accumulator saturates on the third 0xFFFF
      bus17.start = 1; bus17.len = 8'd3;
      tick();
      bus17.start = 0;
      bus17.in_valid = 1; bus17.in_data = 16'hFFFF;
      tick();
      tick();
      chk("sat_accum_sum_zero", 32'(bus17.out_sum), 32'h0);
      tick();
      bus17.in_valid = 0;
      chk("sat_out_valid", 32'(bus17.out_valid), 32'h1);
      chk("sat_out_sum", 32'(bus17.out_sum), 32'h1FFFF);
      chk("sat_out_sat", 32'(bus17.out_sat), 32'h1);
      bus17.out_ready = 1;
      tick();
      bus17.out_ready = 0;
      chk("sat_idle_sat", 32'(bus17.out_sat), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/exp_sum_acc.md
EXP_SUM_ACC -- requirements
Module: exp_sum_acc

Interface
REQ-001 Parameter Bf, default 8, number of fractional bits of in_data and out_sum.
REQ-002 Parameter FIX_POINT_WIDTH, default 16, width of in_data.
REQ-003 Parameter ACC_WIDTH, default 24, width of the accumulator and out_sum; SHALL be at least FIX_POINT_WIDTH+1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a new vector; honoured only in IDLE.
REQ-007 len  input  8  vector length latched on start; 1..255 literal, 0 means 256.
REQ-008 clr  input  1  synchronous abort; returns the block to IDLE from any state.
REQ-009 in_valid  input  1  in_data is valid.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 in_data  input  FIX_POINT_WIDTH  unsigned exp2 result (out1 of the exponent stage), Bf fractional bits.
REQ-012 out_valid  output  1  out_sum and out_sat are valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_sum  output  ACC_WIDTH  unsigned sum of the vector, Bf fractional bits.
REQ-015 out_sat  output  1  out_sum saturated during this vector.
REQ-016 busy  output  1  high in ACCUM and DONE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-018 In IDLE: in_ready=0, out_valid=0, busy=0; start=1 latches len, clears acc, cnt and sat, and moves to ACCUM next cycle.
REQ-019 In ACCUM: in_ready=1; each beat with in_valid&in_ready adds zero-extended in_data to acc and increments cnt.
REQ-020 The beat on which cnt reaches the element count SHALL be the last; the FSM enters DONE on the following cycle (out_valid one cycle after the last accepted beat).
REQ-021 In ACCUM with in_valid=0, acc and cnt SHALL hold; there is no timeout.
REQ-022 Addition SHALL saturate: if acc+in_data >= 2^ACC_WIDTH, acc becomes all-ones and sat is set; sat is sticky until the next start.
REQ-023 In DONE: in_ready=0, out_valid=1, out_sum=acc, out_sat=sat; out_sum and out_sat SHALL stay stable until out_valid&out_ready.
REQ-024 On out_valid&out_ready the FSM SHALL return to IDLE next cycle; a start in that same cycle is ignored.
REQ-025 start in ACCUM or DONE SHALL be ignored with no state change.
REQ-026 clr SHALL have priority over every other input; the next state is IDLE, acc, cnt and sat are cleared, and no output handshake occurs.
REQ-027 len=0 SHALL accumulate exactly 256 beats; cnt SHALL be 9 bits wide so that it does not wrap.
REQ-028 out_sum SHALL read 0 whenever out_valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE; acc, cnt, len register and sat to 0; in_ready=0, out_valid=0, out_sum=0, out_sat=0, busy=0.
REQ-030 Reset asserted mid-vector SHALL discard the partial sum; after release the block waits for a new start.

Structure
REQ-031 The FSM state enumeration and the default widths (Bf, FIX_POINT_WIDTH, ACC_WIDTH) SHALL reside in the shared package nfm_pkg.
REQ-032 A single sub-module, sat_add (unsigned saturating adder that outputs sum and an overflow flag), SHALL be instantiated once.

Verification
REQ-033 start with len=4; beats 0x0100, 0x0080, 0x0040, 0x0020 -> out_valid one cycle after the 4th beat, out_sum=0x0001E0, out_sat=0.
REQ-034 len=0 with 256 beats of 0x0100 -> exactly 256 beats accepted, out_sum=0x010000, out_sat=0; the 257th cycle shows in_ready=0.
REQ-035 ACC_WIDTH=17, len=3, beats 0xFFFF ×3 -> out_sum=0x1FFFF, out_sat=1.
REQ-036 In DONE hold out_ready=0 for 5 cycles while pulsing start -> out_sum stable and state unchanged; out_ready=1 -> IDLE next cycle.
REQ-037 clr asserted after 2 of 4 beats -> IDLE next cycle with no out_valid; a new start with len=1 and beat 0x0005 -> out_sum=0x000005.
REQ-038 rst_n asserted mid-ACCUM -> all outputs are 0 immediately; the block stays in IDLE until a new start.
